// File: rtl/tcm_port_arb.sv
// Three-port arbiter/sequencer in front of the single-port 8k x 32 TCM.
// Shares the SRAM port between ifetch, core data and debug, and steers each response back to its issuer.
module tcm_port_arb #(
   parameter int STARVE_MAX = 4,
   parameter int AW         = 13
) (
   input  logic          clk_i,
   input  logic          rst_i,

   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [31:0]   if_rdata_o,

   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [31:0]   d_wdata_i,
   input  logic [3:0]    d_wstrb_i,
   output logic          d_gnt_o,
   output logic          d_rvalid_o,
   output logic [31:0]   d_rdata_o,

   input  logic          dbg_req_i,
   input  logic          dbg_we_i,
   input  logic [AW-1:0] dbg_addr_i,
   input  logic [31:0]   dbg_wdata_i,
   input  logic [3:0]    dbg_wstrb_i,
   output logic          dbg_gnt_o,
   output logic          dbg_rvalid_o,
   output logic [31:0]   dbg_rdata_o,

   output logic [AW-1:0] tcm_addr_o,
   output logic [31:0]   tcm_wdata_o,
   output logic [3:0]    tcm_wstrb_o,
   output logic          tcm_we_o,
   input  logic [31:0]   tcm_rdata_i
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] if_wait;
   logic [3:0] dbg_wait;
   logic       if_starved;
   logic       dbg_starved;
   logic       if_win;
   logic       d_win;
   logic       dbg_win;
   logic [2:0] own_q;

   assign if_starved  = (if_wait == STARVE_LIM);
   assign dbg_starved = (dbg_wait == STARVE_LIM);

   // Starved ports jump the queue; otherwise data beats ifetch beats debug.
   always_comb begin
      if_win  = 1'b0;
      d_win   = 1'b0;
      dbg_win = 1'b0;
      if (!rst_i) begin
         if (dbg_req_i && dbg_starved)     dbg_win = 1'b1;
         else if (if_req_i && if_starved)  if_win  = 1'b1;
         else if (d_req_i)                 d_win   = 1'b1;
         else if (if_req_i)                if_win  = 1'b1;
         else if (dbg_req_i)               dbg_win = 1'b1;
      end
   end

   assign if_gnt_o  = if_win;
   assign d_gnt_o   = d_win;
   assign dbg_gnt_o = dbg_win;

   always_comb begin
      tcm_addr_o  = '0;
      tcm_wdata_o = 32'h0;
      tcm_wstrb_o = 4'h0;
      tcm_we_o    = 1'b0;
      if (if_win) begin
         tcm_addr_o = if_addr_i;
      end else if (d_win) begin
         tcm_addr_o  = d_addr_i;
         tcm_wdata_o = d_wdata_i;
         tcm_we_o    = d_we_i;
         tcm_wstrb_o = d_we_i ? d_wstrb_i : 4'h0;
      end else if (dbg_win) begin
         tcm_addr_o  = dbg_addr_i;
         tcm_wdata_o = dbg_wdata_i;
         tcm_we_o    = dbg_we_i;
         tcm_wstrb_o = dbg_we_i ? dbg_wstrb_i : 4'h0;
      end
   end

   // Lost-cycle counters saturate so a starved port stays starved until it wins.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         if_wait  <= 4'h0;
         dbg_wait <= 4'h0;
      end else begin
         if (if_req_i && !if_win)
            if_wait <= if_starved ? STARVE_LIM : if_wait + 4'h1;
         else
            if_wait <= 4'h0;
         if (dbg_req_i && !dbg_win)
            dbg_wait <= dbg_starved ? STARVE_LIM : dbg_wait + 4'h1;
         else
            dbg_wait <= 4'h0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) own_q <= 3'b000;
      else       own_q <= {dbg_win, d_win, if_win};
   end

   assign if_rvalid_o  = own_q[0];
   assign d_rvalid_o   = own_q[1];
   assign dbg_rvalid_o = own_q[2];
   assign if_rdata_o   = own_q[0] ? tcm_rdata_i : 32'h0;
   assign d_rdata_o    = own_q[1] ? tcm_rdata_i : 32'h0;
   assign dbg_rdata_o  = own_q[2] ? tcm_rdata_i : 32'h0;

endmodule

// File: tb/tb_tcm_port_arb.sv
// Bench for tcm_port_arb: behavioural SRAM, a reference arbitration/response model
// checked every cycle, and directed vectors with hand-computed literal results.
module tb_tcm_port_arb;

   localparam int STARVE = 4;
   localparam int AW     = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, d_req, d_we, dbg_req, dbg_we;
   logic [AW-1:0] if_addr, d_addr, dbg_addr;
   logic [31:0]   d_wdata, dbg_wdata;
   logic [3:0]    d_wstrb, dbg_wstrb;
   logic          if_gnt, d_gnt, dbg_gnt;
   logic          if_rvalid, d_rvalid, dbg_rvalid;
   logic [31:0]   if_rdata, d_rdata, dbg_rdata;
   logic [AW-1:0] tcm_addr;
   logic [31:0]   tcm_wdata;
   logic [3:0]    tcm_wstrb;
   logic          tcm_we;
   logic [31:0]   tcm_rdata;

   logic [31:0]   tcm_mem [0:8191];
   logic [31:0]   ref_mem [0:8191];

   int n_vec = 0;
   int n_err = 0;

   int            m_if_wait = 0;
   int            m_dbg_wait = 0;
   int            m_pend = 0;
   logic          m_pend_we = 1'b0;
   logic [31:0]   m_pend_data = 32'h0;

   always #5 clk = ~clk;

   tcm_port_arb #(.STARVE_MAX(STARVE), .AW(AW)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_wstrb_i(d_wstrb), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_wstrb_i(dbg_wstrb), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
      .dbg_rdata_o(dbg_rdata),
      .tcm_addr_o(tcm_addr), .tcm_wdata_o(tcm_wdata), .tcm_wstrb_o(tcm_wstrb),
      .tcm_we_o(tcm_we), .tcm_rdata_i(tcm_rdata)
   );

   // SRAM: registered read of the pre-write word, byte-masked write.
   always @(posedge clk) begin
      tcm_rdata <= tcm_mem[tcm_addr];
      if (tcm_we)
         for (int b = 0; b < 4; b++)
            if (tcm_wstrb[b]) tcm_mem[tcm_addr][b*8 +: 8] <= tcm_wdata[b*8 +: 8];
   end

   function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endfunction

   // 0 = none, 1 = ifetch, 2 = data, 3 = debug
   function automatic int pick(bit ir, bit dr, bit gr, int iw, int gw);
      if (gr && gw == STARVE) return 3;
      if (ir && iw == STARVE) return 1;
      if (dr) return 2;
      if (ir) return 1;
      if (gr) return 3;
      return 0;
   endfunction

   // Reference model: evaluated mid-cycle, then advanced to the state after the next edge.
   always @(negedge clk) begin
      int            win;
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      logic [3:0]    es;
      logic          ew;
      if (rst) begin
         check("rst_gnt", 32'({if_gnt, d_gnt, dbg_gnt}), 32'h0);
         check("rst_we", 32'(tcm_we), 32'h0);
         check("rst_rvalid", 32'({if_rvalid, d_rvalid, dbg_rvalid}), 32'h0);
         check("rst_rdata", if_rdata | d_rdata | dbg_rdata, 32'h0);
         m_if_wait = 0;
         m_dbg_wait = 0;
         m_pend = 0;
      end else begin
         check("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
         check("d_rvalid", 32'(d_rvalid), 32'(m_pend == 2));
         check("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pend == 3));
         check("if_rdata", if_rdata, (m_pend == 1) ? m_pend_data : 32'h0);
         if (m_pend != 2) check("d_rdata", d_rdata, 32'h0);
         else if (!m_pend_we) check("d_rdata", d_rdata, m_pend_data);
         if (m_pend != 3) check("dbg_rdata", dbg_rdata, 32'h0);
         else if (!m_pend_we) check("dbg_rdata", dbg_rdata, m_pend_data);

         win = pick(if_req, d_req, dbg_req, m_if_wait, m_dbg_wait);
         check("gnt", 32'({dbg_gnt, d_gnt, if_gnt}),
               32'({win == 3, win == 2, win == 1}));
         ea = '0; ed = 32'h0; es = 4'h0; ew = 1'b0;
         case (win)
            1: ea = if_addr;
            2: begin ea = d_addr; ed = d_wdata; ew = d_we; es = d_we ? d_wstrb : 4'h0; end
            3: begin ea = dbg_addr; ed = dbg_wdata; ew = dbg_we; es = dbg_we ? dbg_wstrb : 4'h0; end
            default: ;
         endcase
         check("tcm_addr", 32'(tcm_addr), 32'(ea));
         check("tcm_wdata", tcm_wdata, ed);
         check("tcm_wstrb", 32'(tcm_wstrb), 32'(es));
         check("tcm_we", 32'(tcm_we), 32'(ew));

         m_pend = win;
         m_pend_we = ew;
         m_pend_data = ref_mem[ea];
         if (ew)
            for (int b = 0; b < 4; b++)
               if (es[b]) ref_mem[ea][b*8 +: 8] = ed[b*8 +: 8];
         m_if_wait  = (if_req && win != 1) ? ((m_if_wait < STARVE) ? m_if_wait + 1 : STARVE) : 0;
         m_dbg_wait = (dbg_req && win != 3) ? ((m_dbg_wait < STARVE) ? m_dbg_wait + 1 : STARVE) : 0;
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_all();
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
   endtask

   task automatic apply_stimulus_contention(int cycles, output int got [0:15]);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         #1;
         got[c] = if_gnt ? 1 : d_gnt ? 2 : dbg_gnt ? 3 : 0;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int got [0:15];
      int exp_two [0:9];
      int exp_three [0:10];
      exp_two   = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
      exp_three = '{2, 2, 2, 2, 3, 1, 2, 2, 2, 3, 1};

      for (int i = 0; i < 8192; i++) begin
         tcm_mem[i] = 32'h5A5A0000 ^ 32'(i * 7);
         ref_mem[i] = tcm_mem[i];
      end
      tcm_mem[16'h0010] = 32'hDEADBEEF; ref_mem[16'h0010] = 32'hDEADBEEF;
      tcm_mem[16'h1FFF] = 32'hAAAAAAAA; ref_mem[16'h1FFF] = 32'hAAAAAAAA;

      rst = 1'b1;
      idle_all();
      if_addr = '0; d_addr = '0; dbg_addr = '0;
      d_wdata = 32'h0; dbg_wdata = 32'h0; d_wstrb = 4'h0; dbg_wstrb = 4'h0;
      step(2);
      rst = 1'b0;
      step(1);

      // Single ifetch read
      if_req = 1'b1; if_addr = 13'h0010;
      step(1);
      if_req = 1'b0;
      check("lit_if_rvalid", 32'(if_rvalid), 32'h1);
      check("lit_if_rdata", if_rdata, 32'hDEADBEEF);
      check("lit_d_rvalid_quiet", 32'({d_rvalid, dbg_rvalid}), 32'h0);
      step(1);

      // Byte write then read at the top address
      d_req = 1'b1; d_we = 1'b1; d_addr = 13'h1FFF; d_wdata = 32'h11223344; d_wstrb = 4'b0101;
      step(1);
      d_we = 1'b0; d_wstrb = 4'h0;
      check("lit_wr_ack", 32'(d_rvalid), 32'h1);
      step(1);
      d_req = 1'b0;
      check("lit_rd_after_wr", d_rdata, 32'hAA22AA44);
      step(1);

      // data vs ifetch contention
      d_req = 1'b1; d_addr = 13'h0005; if_req = 1'b1; if_addr = 13'h0006;
      apply_stimulus_contention(10, got);
      for (int c = 0; c < 10; c++) check("lit_two_way", 32'(got[c]), 32'(exp_two[c]));
      idle_all();
      step(1);

      // all three contending
      d_req = 1'b1; if_req = 1'b1; dbg_req = 1'b1; dbg_addr = 13'h0007;
      apply_stimulus_contention(11, got);
      for (int c = 0; c < 11; c++) check("lit_three_way", 32'(got[c]), 32'(exp_three[c]));
      step(10);
      idle_all();
      step(1);

      // back-to-back alternation ifetch read / data write
      for (int k = 0; k < 8; k++) begin
         idle_all();
         if (k % 2 == 0) begin
            if_req = 1'b1; if_addr = 13'(16'h0100 + k);
         end else begin
            d_req = 1'b1; d_we = 1'b1; d_addr = 13'(16'h0200 + k);
            d_wdata = 32'hC0DE0000 + 32'(k); d_wstrb = 4'hF;
         end
         step(1);
      end
      idle_all();
      d_req = 1'b1; d_addr = 13'h0203;
      step(1);
      dbg_req = 1'b1; d_req = 1'b0; dbg_addr = 13'h0205;
      step(1);
      idle_all();
      check("lit_dbg_rd_written", dbg_rdata, 32'hC0DE0005);
      step(1);

      // reset with a debug read in flight
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 13'h0ABC;
      @(negedge clk);
      #1;
      check("lit_dbg_gnt", 32'(dbg_gnt), 32'h1);
      #2;
      rst = 1'b1;
      dbg_req = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 13'h0011; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'hF;
      @(posedge clk);
      #1;
      check("lit_rst_no_rvalid", 32'(dbg_rvalid), 32'h0);
      check("lit_rst_no_we", 32'(tcm_we), 32'h0);
      step(1);
      idle_all();
      rst = 1'b0;
      step(1);
      check("lit_post_rst_quiet", 32'({if_rvalid, d_rvalid, dbg_rvalid}), 32'h0);
      dbg_req = 1'b1; dbg_addr = 13'h0010;
      step(1);
      dbg_req = 1'b0; if_req = 1'b1; if_addr = 13'h0011;
      check("lit_post_rst_dbg", dbg_rdata, 32'hDEADBEEF);
      step(1);
      idle_all();
      step(3);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tcm_port_arb.md
Name: tcm_port_arb

Overview:
- Three-requester arbiter and sequencer in front of the 32KB single-port TCM (8k x 32, 1-cycle registered read, byte strobes).
- Shares the one SRAM port between instruction fetch, core data load/store, and the debug/trace access port.
- Tracks the 1-cycle read latency and routes each response back to the port that issued it.
- Sits between the core/debug interconnect and the TCM instance.

Parameters:
- STARVE_MAX, 4: consecutive lost cycles after which a waiting ifetch or dbg request is force-granted (range 1..15).
- AW, 13: TCM word-address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- if_req_i  in  1  ifetch read request.
- if_addr_i  in  AW  ifetch word address.
- if_gnt_o  out  1  ifetch accepted this cycle (combinational).
- if_rvalid_o  out  1  ifetch read data valid.
- if_rdata_o  out  32  ifetch read data.
- d_req_i  in  1  data request.
- d_we_i  in  1  data write (1) / read (0).
- d_addr_i  in  AW  data word address.
- d_wdata_i  in  32  data write data.
- d_wstrb_i  in  4  data byte strobes.
- d_gnt_o  out  1  data accepted this cycle (combinational).
- d_rvalid_o  out  1  data response; read data or write acknowledge.
- d_rdata_o  out  32  data read data.
- dbg_req_i, dbg_we_i, dbg_addr_i[AW], dbg_wdata_i[32], dbg_wstrb_i[4]  in  debug port, same semantics as the data port.
- dbg_gnt_o  out  1  debug accepted (combinational).
- dbg_rvalid_o  out  1  debug response.
- dbg_rdata_o  out  32  debug read data.
- tcm_addr_o  out  AW  to TCM address.
- tcm_wdata_o  out  32  to TCM write data.
- tcm_wstrb_o  out  4  to TCM byte strobes.
- tcm_we_o  out  1  to TCM write enable.
- tcm_rdata_i  in  32  from TCM read data (valid the cycle after the address).

Behaviour:
- Handshake:
  - A transfer is accepted in the cycle where req && gnt.
  - Requesters hold req and all request fields stable until gnt.
  - The block does not latch requests.
  - At most one gnt is high per cycle; gnt is never high without the matching req.
- Priority, evaluated each cycle: dbg_starved > if_starved > data > ifetch > dbg.
  - x_starved = (x_wait == STARVE_MAX).
- Wait counters, if_wait and dbg_wait (4 bit):
  - Increment when req && !gnt, saturating at STARVE_MAX.
  - Clear when the port is granted or its req is low.
  - Reset to 0.
- TCM drive in the grant cycle: tcm_addr_o, tcm_wdata_o, tcm_wstrb_o, tcm_we_o come from the winner.
  - tcm_we_o = winner_we; always 0 for ifetch.
  - tcm_wstrb_o is forced to 0 when tcm_we_o = 0.
  - With no winner: addr = 0, wdata = 0, wstrb = 0, we = 0.
- Response pipeline:
  - Registered owner vector own_q[2:0] (one-hot or zero) is set from the grant at each posedge.
  - In cycle N+1: x_rvalid_o = own_q[x].
  - x_rdata_o = tcm_rdata_i when own_q[x], else 32'h0.
  - Writes also produce rvalid at N+1 (write ack); rdata on a write ack is the pre-write word and must be ignored.
- Throughput: back-to-back grants are allowed every cycle, to the same or different ports. Responses cannot be back-pressured.
- Read-after-write to the same address on consecutive grants returns the newly written data (SRAM property; no forwarding in this block).
- Reset values (asynchronous on rst_i):
  - own_q = 0; all rvalid_o = 0; all rdata_o = 0; wait counters = 0.
  - All gnt_o = 0 and tcm_we_o = 0 while rst_i is high.
  - A response in flight at reset is dropped; no rvalid after release.
- Simultaneous requests:
  - Both starved: dbg wins.
  - The losing port keeps its counter saturated and wins the next cycle if still starved.
- Address range: full AW range, no decode or error response; wrap is handled by the owner of the address map.

Test Plan:
- Single reads: if_req with addr 0x0010, mem[0x10] = 0xDEADBEEF -> if_gnt same cycle; next cycle if_rvalid = 1, if_rdata = 0xDEADBEEF; d/dbg rvalid = 0.
- Byte write then read: d write addr 0x1FFF, wdata 0x11223344, wstrb 4'b0101 over 0xAAAAAAAA -> ack next cycle; a following d read returns 0xAA22AA44.
- Contention: d_req and if_req held high continuously, STARVE_MAX = 4 -> grants d,d,d,d,if repeating; if_wait sequence 1,2,3,4,0.
- All three requesting, STARVE_MAX = 4, held high -> dbg never starves beyond 4 lost cycles; dbg is granted before ifetch whenever both counters equal 4.
- Back-to-back alternation if,d,if,d on distinct addresses -> every cycle exactly one rvalid, on the correct port and with the correct data; tcm_we_o high only in d write cycles.
- Reset mid-flight: grant a dbg read, assert rst_i before the next posedge -> dbg_rvalid stays 0, counters 0, tcm_we_o = 0; normal operation resumes after release.
